// File: rtl/trace_pkg.sv
// Shared types and default widths for the writeback trace monitor.
package trace_pkg;

  localparam int DEF_DW    = 32;
  localparam int DEF_RAW   = 5;
  localparam int DEF_PCW   = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_CNTW  = 32;

  // Trace record layout at the default widths; the top rebuilds it for its own parameters.
  typedef struct packed {
    logic [DEF_RAW-1:0] rd;
    logic [DEF_DW-1:0]  data;
    logic [DEF_PCW-1:0] pc;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mon_state_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a registered read port; a push into an empty FIFO
// becomes visible on dout one cycle later.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    head_next;
  logic [LW-1:0]    count_reg;
  logic [WIDTH-1:0] dout_reg;
  logic             do_push;
  logic             do_pop;

  assign full      = (count_reg == LW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
  assign dout      = dout_reg;
  assign level     = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      rd_ptr_reg <= head_next;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + LW'(1);
        2'b01:   count_reg <= count_reg - LW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Read the next head every cycle; bypass din when the push lands on that slot (empty FIFO).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_reg <= '0;
    end else if (do_push && (wr_ptr_reg == head_next)) begin
      dout_reg <= din;
    end else begin
      dout_reg <= mem[head_next];
    end
  end

endmodule

// File: rtl/wb_trace_monitor.sv
// Writeback-stage monitor: counts cycles and retirements during a run and
// logs register-file writes into a drainable trace FIFO.
module wb_trace_monitor
  import trace_pkg::*;
#(
  parameter int DW          = DEF_DW,
  parameter int RAW         = DEF_RAW,
  parameter int PCW         = DEF_PCW,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CNTW        = DEF_CNTW,
  parameter int INSTR_LIMIT = 20,
  parameter int CYCLE_LIMIT = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   wb_valid,
  input  logic                   wb_we,
  input  logic [RAW-1:0]         wb_rd,
  input  logic [DW-1:0]          wb_data,
  input  logic [PCW-1:0]         wb_pc,
  output logic                   tr_valid,
  input  logic                   tr_ready,
  output logic [RAW-1:0]         tr_rd,
  output logic [DW-1:0]          tr_data,
  output logic [PCW-1:0]         tr_pc,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNTW-1:0]        cycle_count,
  output logic [CNTW-1:0]        retire_count,
  output logic                   running,
  output logic                   done,
  output logic                   timeout,
  output logic                   overflow
);

  localparam int EW = RAW + DW + PCW;

  typedef struct packed {
    logic [RAW-1:0] rd;
    logic [DW-1:0]  data;
    logic [PCW-1:0] pc;
  } entry_t;

  mon_state_t    state_reg;
  logic [CNTW-1:0] cyc_next;
  logic [CNTW-1:0] ret_next;
  logic          hit_limit;
  logic          hit_cycle;
  logic          push_req;
  logic          fifo_full;
  logic          fifo_empty;
  entry_t        entry_in;
  entry_t        entry_out;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  always_comb begin
    cyc_next  = sat_inc(cycle_count);
    ret_next  = wb_valid ? sat_inc(retire_count) : retire_count;
    hit_limit = (ret_next >= CNTW'(INSTR_LIMIT));
    hit_cycle = (cyc_next >= CNTW'(CYCLE_LIMIT));
  end

  // start wins over a same-cycle write so the new run begins with an empty trace.
  assign push_req = (state_reg == RUN) && !start && wb_valid && wb_we && (wb_rd != '0);
  assign entry_in = '{rd: wb_rd, data: wb_data, pc: wb_pc};

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (start),
    .push  (push_req),
    .pop   (tr_ready),
    .din   (entry_in),
    .dout  (entry_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign tr_valid = !fifo_empty;
  assign tr_rd    = entry_out.rd;
  assign tr_data  = entry_out.data;
  assign tr_pc    = entry_out.pc;
  assign running  = (state_reg == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cycle_count  <= '0;
      retire_count <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else if (start) begin
      state_reg    <= RUN;
      cycle_count  <= '0;
      retire_count <= '0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      // A full FIFO only has room this cycle if the head is being popped.
      if (push_req && fifo_full && !tr_ready) begin
        overflow <= 1'b1;
      end
      if (state_reg == RUN) begin
        cycle_count  <= cyc_next;
        retire_count <= ret_next;
        if (hit_limit) begin
          state_reg <= DONE;
          done      <= 1'b1;
        end else if (hit_cycle) begin
          state_reg <= DONE;
          done      <= 1'b1;
          timeout   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed bench: a small-limit instance for run termination, a default-limit
// instance for FIFO overflow, backpressure and reset behaviour.
`define CHK(nm, act, exp) chk(nm, 64'(act), 64'(exp))

module tb_wb_trace_monitor;

  logic        clk;
  logic        rst_n;
  logic        start_a;
  logic        start_b;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] wb_pc;
  logic        tr_ready;

  logic        a_tr_valid, b_tr_valid;
  logic [4:0]  a_tr_rd, b_tr_rd;
  logic [31:0] a_tr_data, b_tr_data;
  logic [31:0] a_tr_pc, b_tr_pc;
  logic [2:0]  a_level, b_level;
  logic [31:0] a_cycle, b_cycle;
  logic [31:0] a_retire, b_retire;
  logic        a_running, b_running;
  logic        a_done, b_done;
  logic        a_timeout, b_timeout;
  logic        a_overflow, b_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  wb_trace_monitor #(
    .DEPTH(4), .INSTR_LIMIT(4), .CYCLE_LIMIT(10)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .tr_valid(a_tr_valid), .tr_ready(tr_ready), .tr_rd(a_tr_rd), .tr_data(a_tr_data),
    .tr_pc(a_tr_pc), .level(a_level), .cycle_count(a_cycle), .retire_count(a_retire),
    .running(a_running), .done(a_done), .timeout(a_timeout), .overflow(a_overflow)
  );

  wb_trace_monitor #(
    .DEPTH(4), .INSTR_LIMIT(20), .CYCLE_LIMIT(1000)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_pc(wb_pc),
    .tr_valid(b_tr_valid), .tr_ready(tr_ready), .tr_rd(b_tr_rd), .tr_data(b_tr_data),
    .tr_pc(b_tr_pc), .level(b_level), .cycle_count(b_cycle), .retire_count(b_retire),
    .running(b_running), .done(b_done), .timeout(b_timeout), .overflow(b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        st;
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        e_run;
    logic        e_done;
    logic        e_to;
    logic [31:0] e_cyc;
    logic [31:0] e_ret;
    logic [2:0]  e_lvl;
    logic        e_tv;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic v, input logic we, input logic [4:0] rd,
                        input logic [31:0] data, input logic [31:0] pc);
    wb_valid = v;
    wb_we    = we;
    wb_rd    = rd;
    wb_data  = data;
    wb_pc    = pc;
  endtask

  task automatic start_b_run();
    start_b = 1'b1;
    step();
    start_b = 1'b0;
  endtask

  task automatic drain_b(input string tag, input int n, input logic [4:0] rds [8]);
    tr_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      `CHK($sformatf("%s.valid%0d", tag, i), b_tr_valid, 1'b1);
      `CHK($sformatf("%s.rd%0d", tag, i), b_tr_rd, rds[i]);
      $display("[TB] %s pop rd=%0d data=0x%0h", tag, b_tr_rd, b_tr_data);
      step();
    end
    `CHK($sformatf("%s.empty", tag), b_tr_valid, 1'b0);
    `CHK($sformatf("%s.level0", tag), b_level, 3'd0);
    tr_ready = 1'b0;
  endtask

  logic [4:0] exp_rds [8];
  int         got;
  int         pushed;
  logic       stalled;
  logic [4:0] stall_rd;
  logic [31:0] stall_data;

  initial begin
    rst_n    = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    tr_ready = 1'b0;
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

    //               st   v    we   rd    data         pc       run  done to   cyc    ret    lvl   tv   erd   edata    epc
    vecs[0] = '{1'b1,1'b0,1'b0,5'd0,32'h0,      32'h0,  1'b1,1'b0,1'b0,32'd0,32'd0,3'd0,1'b0,5'd0,32'h0,32'h0};
    vecs[1] = '{1'b0,1'b1,1'b1,5'd3,32'h1,      32'h0,  1'b1,1'b0,1'b0,32'd1,32'd1,3'd1,1'b1,5'd3,32'h1,32'h0};
    vecs[2] = '{1'b0,1'b1,1'b1,5'd0,32'hdead,   32'h4,  1'b1,1'b0,1'b0,32'd2,32'd2,3'd1,1'b1,5'd3,32'h1,32'h0};
    vecs[3] = '{1'b0,1'b1,1'b1,5'd0,32'hbeef,   32'h8,  1'b1,1'b0,1'b0,32'd3,32'd3,3'd1,1'b1,5'd3,32'h1,32'h0};
    vecs[4] = '{1'b0,1'b1,1'b1,5'd0,32'h0,      32'hc,  1'b0,1'b1,1'b0,32'd4,32'd4,3'd1,1'b1,5'd3,32'h1,32'h0};
    vecs[5] = '{1'b0,1'b1,1'b1,5'd5,32'h7,      32'h10, 1'b0,1'b1,1'b0,32'd4,32'd4,3'd1,1'b1,5'd3,32'h1,32'h0};

    repeat (2) @(posedge clk);
    #1;
    `CHK("reset.a_running", a_running, 1'b0);
    `CHK("reset.a_level", a_level, 3'd0);
    `CHK("reset.a_tr_valid", a_tr_valid, 1'b0);
    `CHK("reset.b_done", b_done, 1'b0);
    `CHK("reset.b_cycle", b_cycle, 32'd0);
    `CHK("reset.b_tr_rd", b_tr_rd, 5'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      start_a = vecs[i].st;
      set_wb(vecs[i].v, vecs[i].we, vecs[i].rd, vecs[i].data, vecs[i].pc);
      step();
      start_a = 1'b0;
      `CHK($sformatf("vec%0d.running", i), a_running, vecs[i].e_run);
      n_tests++;
      if (a_done !== vecs[i].e_done) begin
        n_fail++;
        $display("FAIL vec%0d.done: got 0x%0h expected 0x%0h", i, a_done, vecs[i].e_done);
      end
      `CHK($sformatf("vec%0d.timeout", i), a_timeout, vecs[i].e_to);
      `CHK($sformatf("vec%0d.cycle", i), a_cycle, vecs[i].e_cyc);
      n_tests++;
      if (a_retire !== vecs[i].e_ret) begin
        n_fail++;
        $display("FAIL vec%0d.retire: got 0x%0h expected 0x%0h", i, a_retire, vecs[i].e_ret);
      end
      `CHK($sformatf("vec%0d.level", i), a_level, vecs[i].e_lvl);
      `CHK($sformatf("vec%0d.tr_valid", i), a_tr_valid, vecs[i].e_tv);
      if (vecs[i].e_tv) begin
        `CHK($sformatf("vec%0d.tr_rd", i), a_tr_rd, vecs[i].e_rd);
        `CHK($sformatf("vec%0d.tr_data", i), a_tr_data, vecs[i].e_data);
        `CHK($sformatf("vec%0d.tr_pc", i), a_tr_pc, vecs[i].e_pc);
      end
      $display("[TB] vec %0d ret=%0d cyc=%0d lvl=%0d done=%0d", i, a_retire, a_cycle, a_level, a_done);
    end
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);

    start_a = 1'b1;
    step();
    start_a = 1'b0;
    `CHK("to.start_level", a_level, 3'd0);
    `CHK("to.start_running", a_running, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step();
      if (k == 9) `CHK("to.done_early", a_done, 1'b0);
    end
    `CHK("to.done", a_done, 1'b1);
    `CHK("to.timeout", a_timeout, 1'b1);
    n_tests++;
    if (a_cycle !== 32'd10) begin
      n_fail++;
      $display("FAIL to.cycle: got 0x%0h expected 0x%0h", a_cycle, 32'd10);
    end
    `CHK("to.level", a_level, 3'd0);
    `CHK("to.running", a_running, 1'b0);
    $display("[TB] timeout run cyc=%0d timeout=%0d", a_cycle, a_timeout);

    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      set_wb(k >= 7, 1'b0, 5'd0, 32'h0, 32'(k * 4));
      step();
      if (k == 9) `CHK("both.done_early", a_done, 1'b0);
    end
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    `CHK("both.done", a_done, 1'b1);
    `CHK("both.timeout", a_timeout, 1'b0);
    `CHK("both.retire", a_retire, 32'd4);
    `CHK("both.cycle", a_cycle, 32'd10);
    $display("[TB] both-limit run ret=%0d cyc=%0d timeout=%0d", a_retire, a_cycle, a_timeout);

    start_b_run();
    for (int i = 1; i <= 6; i++) begin
      set_wb(1'b1, 1'b1, 5'(i), 32'(i * 16), 32'(i * 4));
      step();
      if (i == 4) begin
        `CHK("ovf.level_full", b_level, 3'd4);
        `CHK("ovf.not_yet", b_overflow, 1'b0);
      end
    end
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    `CHK("ovf.level", b_level, 3'd4);
    `CHK("ovf.flag", b_overflow, 1'b1);
    `CHK("ovf.head_data", b_tr_data, 32'h10);
    for (int i = 0; i < 4; i++) exp_rds[i] = 5'(i + 1);
    drain_b("ovf", 4, exp_rds);
    `CHK("ovf.sticky", b_overflow, 1'b1);

    start_b_run();
    `CHK("fp.ovf_cleared", b_overflow, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      set_wb(1'b1, 1'b1, 5'(i), 32'(i), 32'(i * 4));
      step();
    end
    `CHK("fp.level_full", b_level, 3'd4);
    set_wb(1'b1, 1'b1, 5'd9, 32'h99, 32'h90);
    tr_ready = 1'b1;
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    `CHK("fp.level", b_level, 3'd4);
    `CHK("fp.overflow", b_overflow, 1'b0);
    exp_rds[0] = 5'd2; exp_rds[1] = 5'd3; exp_rds[2] = 5'd4; exp_rds[3] = 5'd9;
    drain_b("fp", 4, exp_rds);

    start_b_run();
    got     = 0;
    pushed  = 0;
    stalled = 1'b0;
    stall_rd   = '0;
    stall_data = '0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      if (pushed < 8) begin
        set_wb(1'b1, 1'b1, 5'(pushed + 1), 32'(256 + pushed + 1), 32'(pushed * 4));
        pushed++;
      end else begin
        set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
      end
      tr_ready = c[0];
      if (stalled) begin
        `CHK($sformatf("bp.stable_rd_c%0d", c), b_tr_rd, stall_rd);
        `CHK($sformatf("bp.stable_data_c%0d", c), b_tr_data, stall_data);
      end
      if (b_tr_valid && tr_ready) begin
        n_tests++;
        if (b_tr_rd !== 5'(got + 1)) begin
          n_fail++;
          $display("FAIL bp.rd%0d: got 0x%0h expected 0x%0h", got, b_tr_rd, got + 1);
        end
        `CHK($sformatf("bp.data%0d", got), b_tr_data, 32'(256 + got + 1));
        $display("[TB] bp pop rd=%0d data=0x%0h", b_tr_rd, b_tr_data);
        got++;
      end
      stalled    = b_tr_valid && !tr_ready;
      stall_rd   = b_tr_rd;
      stall_data = b_tr_data;
      step();
    end
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    tr_ready = 1'b0;
    `CHK("bp.received", got, 8);
    `CHK("bp.level", b_level, 3'd0);
    `CHK("bp.overflow", b_overflow, 1'b0);

    start_b_run();
    for (int i = 1; i <= 3; i++) begin
      set_wb(1'b1, 1'b1, 5'(i), 32'(i), 32'(i));
      step();
    end
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    step();
    `CHK("rst.level_before", b_level, 3'd3);
    #2;
    rst_n = 1'b0;
    #1;
    `CHK("rst.level", b_level, 3'd0);
    `CHK("rst.tr_valid", b_tr_valid, 1'b0);
    `CHK("rst.cycle", b_cycle, 32'd0);
    `CHK("rst.retire", b_retire, 32'd0);
    `CHK("rst.running", b_running, 1'b0);
    `CHK("rst.tr_rd", b_tr_rd, 5'd0);
    `CHK("rst.tr_data", b_tr_data, 32'd0);
    #2;
    rst_n = 1'b1;
    step();
    `CHK("rst.idle", b_running, 1'b0);
    start_b_run();
    `CHK("rst.restart_running", b_running, 1'b1);
    `CHK("rst.restart_cycle", b_cycle, 32'd0);
    `CHK("rst.restart_level", b_level, 3'd0);
    set_wb(1'b1, 1'b1, 5'd7, 32'h77, 32'h70);
    step();
    set_wb(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    `CHK("rst.new_cycle", b_cycle, 32'd1);
    `CHK("rst.new_retire", b_retire, 32'd1);
    `CHK("rst.new_level", b_level, 3'd1);
    `CHK("rst.new_rd", b_tr_rd, 5'd7);
    `CHK("rst.new_pc", b_tr_pc, 32'h70);
    $display("[TB] restart cyc=%0d ret=%0d lvl=%0d", b_cycle, b_retire, b_level);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
